// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader that assembles a big-endian byte stream into
//               32-bit instruction words, writes them to instruction memory,
//               then holds the CPU in reset for RST_HOLD cycles before
//               releasing it. Overflow (and checksum mismatch) latch a fault.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- the byte
//               carrying in_last becomes a modulo-256 checksum trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int ADDR_W   = 8,
   parameter int RST_HOLD = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [7:0]        in_data_i,
   input  logic              in_last_i,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_addr_o,
   output logic [31:0]       im_wdata_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ADDR_W:0]   word_count_o
);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_FLUSH = 3'd1,
      S_HOLD  = 3'd2,
      S_RUN   = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   // Memory is full once word_count reaches 2**ADDR_W.
   localparam logic [ADDR_W:0] C_WC_FULL   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] C_WC_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam int              HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [HOLD_W-1:0] C_HOLD_ONE  = HOLD_W'(1);

   state_t              state_q, state_d;
   logic [1:0]          bcnt_q, bcnt_d;     // bytes held in the assembler
   logic [31:0]         asm_q, asm_d;       // word assembler, newest byte at LSB
   logic [ADDR_W:0]     wc_q, wc_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                rdy_q;              // gates in_ready until the first edge after reset
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
`endif

   logic                w_xfer;
   logic                w_is_data;
   logic [31:0]         w_word;
   logic [31:0]         w_pad;

   assign in_ready_o   = rdy_q & ((state_q == S_LOAD) | (state_q == S_FAULT));
   assign cpu_rst_o    = (state_q != S_RUN);
   assign done_o       = (state_q == S_RUN);
   assign error_o      = err_q;
   assign im_we_o      = we_q;
   assign im_addr_o    = addr_q;
   assign im_wdata_o   = wdata_q;
   assign word_count_o = wc_q;

   // Next-state, assembler, write-port and counter logic.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      asm_d   = asm_q;
      wc_d    = wc_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      hold_d  = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d     = sum_q;
      // The trailer byte is compared, never stored.
      w_is_data = ~in_last_i;
`else
      w_is_data = 1'b1;
`endif
      w_xfer = in_valid_i & in_ready_o;
      w_word = {asm_q[23:0], in_data_i};

      // Left-justify a partial word, zero-filling the missing low bytes.
      w_pad = asm_q;
      case (bcnt_q)
         2'd1:    w_pad = {asm_q[7:0],  24'h0};
         2'd2:    w_pad = {asm_q[15:0], 16'h0};
         2'd3:    w_pad = {asm_q[23:0],  8'h0};
         default: w_pad = asm_q;
      endcase

      case (state_q)
         S_LOAD: begin
            if (w_xfer) begin
               if (w_is_data) begin
                  asm_d  = w_word;
                  bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_d  = sum_q + in_data_i;
`endif
                  if (bcnt_q == 2'd3) begin
                     if (wc_q == C_WC_FULL) begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                     end else begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = w_word;
                        wc_d    = wc_q + C_WC_ONE;
                     end
                  end
               end
               if (in_last_i && (state_d != S_FAULT)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (in_data_i != sum_q) begin
                     err_d   = 1'b1;
                     state_d = S_FAULT;
                  end else
`endif
                  if (bcnt_d != 2'd0) begin
                     state_d = S_FLUSH;
                  end else begin
                     state_d = S_HOLD;
                     hold_d  = '0;
                  end
               end
            end
         end
         S_FLUSH: begin
            bcnt_d = 2'd0;
            asm_d  = '0;
            if (wc_q == C_WC_FULL) begin
               err_d   = 1'b1;
               state_d = S_FAULT;
            end else begin
               we_d    = 1'b1;
               addr_d  = wc_q[ADDR_W-1:0];
               wdata_d = w_pad;
               wc_d    = wc_q + C_WC_ONE;
               state_d = S_HOLD;
               hold_d  = '0;
            end
         end
         S_HOLD: begin
            if (hold_q == C_HOLD_LAST) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + C_HOLD_ONE;
            end
         end
         S_RUN:   state_d = S_RUN;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_LOAD;
         bcnt_q  <= 2'd0;
         asm_q   <= '0;
         wc_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         hold_q  <= '0;
         rdy_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         wc_q    <= wc_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
         rdy_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Two instances (ADDR_W=8
//               and ADDR_W=2) share one byte stream; a stream-level model
//               predicts the memory writes and final status of each.
//               Honours IMEM_LOADER_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int RST_HOLD = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef logic [39:0]  wr_t;        // {addr zero-extended to 8 bits, data}
   typedef wr_t          wr_q_t[$];
   typedef logic [7:0]   byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        b_ready, b_we, b_cpu_rst, b_done, b_err;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata;
   logic [8:0]  b_wc;

   logic        s_ready, s_we, s_cpu_rst, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;
   logic [2:0]  s_wc;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int fall_cyc = -1;
   wr_t got_b[$];
   wr_t got_s[$];

   imem_loader #(.ADDR_W(8), .RST_HOLD(RST_HOLD)) u_big (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_ready),
      .in_data_i(in_data), .in_last_i(in_last), .im_we_o(b_we), .im_addr_o(b_addr),
      .im_wdata_o(b_wdata), .cpu_rst_o(b_cpu_rst), .done_o(b_done),
      .error_o(b_err), .word_count_o(b_wc));

   imem_loader #(.ADDR_W(2), .RST_HOLD(RST_HOLD)) u_small (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_ready),
      .in_data_i(in_data), .in_last_i(in_last), .im_we_o(s_we), .im_addr_o(s_addr),
      .im_wdata_o(s_wdata), .cpu_rst_o(s_cpu_rst), .done_o(s_done),
      .error_o(s_err), .word_count_o(s_wc));

   always #5 clk = ~clk;

   // Capture memory writes and the CPU-release moment mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (b_we === 1'b1) begin
         got_b.push_back({b_addr, b_wdata});
         last_we_cyc <= cyc;
      end
      if (s_we === 1'b1) got_s.push_back({6'b0, s_addr, s_wdata});
      if (b_cpu_rst === 1'b0 && fall_cyc < 0) fall_cyc <= cyc;
   end

   // Stream-level reference: words are consecutive big-endian groups of four
   // data bytes, a short tail is zero-padded, writes stop at 2**aw words.
   task automatic model(input byte_q_t s, input int aw,
                        output wr_q_t w, output bit err, output int wc);
      int ndata, nfull, rem, cap;
      logic [7:0]  sum;
      logic [31:0] word;
      w = {}; err = 1'b0; wc = 0; cap = 1 << aw; sum = 8'h00;
      ndata = CSUM ? s.size() - 1 : s.size();
      for (int i = 0; i < ndata; i++) sum = sum + s[i];
      nfull = ndata / 4;
      rem   = ndata % 4;
      for (int k = 0; k < nfull && !err; k++) begin
         if (wc == cap) err = 1'b1;
         else begin
            word = {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]};
            w.push_back({8'(wc), word});
            wc++;
         end
      end
      if (!err && CSUM && s[s.size()-1] != sum) err = 1'b1;
      if (!err && rem != 0) begin
         if (wc == cap) err = 1'b1;
         else begin
            word = 32'h0;
            for (int j = 0; j < rem; j++) word = word | ({s[4*nfull+j], 24'h0} >> (8*j));
            w.push_back({8'(wc), word});
            wc++;
         end
      end
   endtask

   // Random image of n data bytes, plus a trailer when checksums are on.
   function automatic byte_q_t make_stream(input int n, input bit corrupt);
      byte_q_t s;
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         s.push_back(8'($urandom_range(0, 255)));
         sum = sum + s[i];
      end
      if (CSUM) s.push_back(corrupt ? sum + 8'h01 : sum);
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got_b.delete(); got_s.delete();
      fall_cyc = -1;
      @(negedge clk);
   endtask

   // Drive the first n bytes (all if n<0); in_last marks the final byte of a
   // full send. Optional random idle gaps, or a fixed gap before byte gap_at.
   task automatic send_stream(input byte_q_t s, input bit rnd_gaps,
                              input int gap_at, input int gap_len, input int n);
      int cnt, guard;
      cnt = (n < 0) ? s.size() : n;
      for (int i = 0; i < cnt; i++) begin
         in_valid = 1'b0; in_last = 1'b0;
         if (rnd_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         if (i == gap_at) repeat (gap_len) @(negedge clk);
         in_valid = 1'b1;
         in_data  = s[i];
         in_last  = (n < 0) && (i == cnt - 1);
         guard = 0;
         while (b_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) begin
            checks++; errors++;
            $display("FAIL ready_timeout byte %0d in_ready=%b required 1", i, b_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({b_ready, b_we, b_addr, b_wdata, b_cpu_rst, b_done, b_err, b_wc} !==
          {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
         errors++;
         $display("FAIL reset_big rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b wc=%0d required 0 0 00 0 1 0 0 0",
                  b_ready, b_we, b_addr, b_wdata, b_cpu_rst, b_done, b_err, b_wc);
      end
      checks++;
      if ({s_ready, s_we, s_cpu_rst, s_done, s_err, s_wc} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_small rdy=%b we=%b cr=%b dn=%b er=%b wc=%0d", s_ready, s_we, s_cpu_rst, s_done, s_err, s_wc);
      end
      rst = 1'b0;
      checks++;
      if (b_ready !== 1'b0) begin
         errors++; $display("FAIL ready_at_release got %b required 0", b_ready);
      end
      @(negedge clk);
      checks++;
      if (b_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_edge got %b required 1", b_ready);
      end
   endtask

`ifndef IMEM_LOADER_CHECKSUM_EN
   task automatic test_vectors();
      byte_q_t s;
      do_reset();
      s = {8'h24, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03};
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != 2 || got_b[0] !== {8'h00, 32'h24080005} || got_b[1] !== {8'h01, 32'h20090003}) begin
         errors++; $display("FAIL vec8_writes n=%0d w0=%h w1=%h required 0024080005 0120090003",
                            got_b.size(), got_b[0], got_b[1]);
      end
      checks++;
      if (b_wc !== 9'd2 || b_done !== 1'b1 || b_cpu_rst !== 1'b0) begin
         errors++; $display("FAIL vec8_status wc=%0d done=%b cpu_rst=%b required 2 1 0", b_wc, b_done, b_cpu_rst);
      end
      checks++;
      if (fall_cyc - last_we_cyc != RST_HOLD) begin
         errors++; $display("FAIL vec8_release_delay got %0d required %0d", fall_cyc - last_we_cyc, RST_HOLD);
      end
      // In RUN, further input must be refused and cause no writes.
      in_valid = 1'b1; in_data = 8'hEE;
      repeat (5) @(negedge clk);
      checks++;
      if (b_ready !== 1'b0 || got_b.size() != 2 || b_done !== 1'b1) begin
         errors++; $display("FAIL run_ignores rdy=%b writes=%0d done=%b required 0 2 1", b_ready, got_b.size(), b_done);
      end
      in_valid = 1'b0;

      do_reset();
      s = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != 2 || got_b[0] !== {8'h00, 32'h11223344} || got_b[1] !== {8'h01, 32'h55000000}) begin
         errors++; $display("FAIL vec5_flush n=%0d w0=%h w1=%h required 0011223344 0155000000",
                            got_b.size(), got_b[0], got_b[1]);
      end

      do_reset();
      s = {8'hA7};
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != 1 || got_b[0] !== {8'h00, 32'hA7000000} || b_done !== 1'b1 || b_wc !== 9'd1) begin
         errors++; $display("FAIL single_byte n=%0d w0=%h done=%b wc=%0d required 1 00A7000000 1 1",
                            got_b.size(), got_b[0], b_done, b_wc);
      end
   endtask
`else
   task automatic test_vectors();
      byte_q_t s;
      do_reset();
      s = {8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != 1 || got_b[0] !== {8'h00, 32'h00000001} || b_done !== 1'b1 || b_err !== 1'b0) begin
         errors++; $display("FAIL csum_good n=%0d w0=%h done=%b err=%b required 1 0000000001 1 0",
                            got_b.size(), got_b[0], b_done, b_err);
      end
      do_reset();
      s = {8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (b_err !== 1'b1 || b_done !== 1'b0 || b_cpu_rst !== 1'b1) begin
         errors++; $display("FAIL csum_bad err=%b done=%b cpu_rst=%b required 1 0 1", b_err, b_done, b_cpu_rst);
      end
   endtask
`endif

   task automatic test_overflow();
      byte_q_t s;
      wr_q_t   exp_s;
      bit      es;
      int      wcs;
      do_reset();
      s = make_stream(CSUM ? 19 : 20, 1'b0);
      model(s, 2, exp_s, es, wcs);
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_s.size() != 4) begin
         errors++; $display("FAIL ovf_write_count got %0d required 4", got_s.size());
      end
      for (int k = 0; k < got_s.size() && k < 4; k++) begin
         checks++;
         if (got_s[k] !== exp_s[k] || got_s[k][33:32] !== 2'(k)) begin
            errors++; $display("FAIL ovf_word%0d got %h required %h", k, got_s[k], exp_s[k]);
         end
      end
      checks++;
      if (s_err !== 1'b1 || s_cpu_rst !== 1'b1 || s_ready !== 1'b1 || s_done !== 1'b0) begin
         errors++; $display("FAIL ovf_status err=%b cpu_rst=%b ready=%b done=%b required 1 1 1 0",
                            s_err, s_cpu_rst, s_ready, s_done);
      end
   endtask

   task automatic test_abort();
      byte_q_t s;
      wr_q_t   exp_b;
      bit      eb;
      int      wcb;
      do_reset();
      s = make_stream(12, 1'b0);
      model(s, 8, exp_b, eb, wcb);
      send_stream(s, 1'b0, -1, 0, 6);
      checks++;
      if (b_wc !== 9'd1) begin
         errors++; $display("FAIL abort_pre_wc got %0d required 1", b_wc);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (b_wc !== 9'd0 || b_ready !== 1'b0 || b_cpu_rst !== 1'b1) begin
         errors++; $display("FAIL abort_async wc=%0d ready=%b cpu_rst=%b required 0 0 1", b_wc, b_ready, b_cpu_rst);
      end
      do_reset();
      send_stream(s, 1'b0, -1, 0, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != 3 || b_err !== 1'b0 || b_wc !== 9'd3) begin
         errors++; $display("FAIL abort_replay n=%0d err=%b wc=%0d required 3 0 3", got_b.size(), b_err, b_wc);
      end
      for (int k = 0; k < got_b.size() && k < exp_b.size(); k++) begin
         checks++;
         if (got_b[k] !== exp_b[k]) begin
            errors++; $display("FAIL abort_word%0d got %h required %h", k, got_b[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_gap();
      byte_q_t s;
      wr_q_t   exp_b;
      bit      eb;
      int      wcb;
      do_reset();
      s = make_stream(8, 1'b0);
      model(s, 8, exp_b, eb, wcb);
      send_stream(s, 1'b0, 2, 3, -1);
      repeat (RST_HOLD + 6) @(negedge clk);
      checks++;
      if (got_b.size() != exp_b.size() || got_b.size() != 2) begin
         errors++; $display("FAIL gap_write_count got %0d required 2", got_b.size());
      end
      for (int k = 0; k < got_b.size() && k < exp_b.size(); k++) begin
         checks++;
         if (got_b[k] !== exp_b[k]) begin
            errors++; $display("FAIL gap_word%0d got %h required %h", k, got_b[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_random();
      byte_q_t s;
      wr_q_t   exp_b, exp_s;
      bit      eb, es;
      int      wcb, wcs;
      for (int t = 0; t < 12; t++) begin
         do_reset();
         s = make_stream($urandom_range(1, 40), ($urandom_range(0, 3) == 0));
         model(s, 8, exp_b, eb, wcb);
         model(s, 2, exp_s, es, wcs);
         send_stream(s, 1'b1, -1, 0, -1);
         repeat (RST_HOLD + 8) @(negedge clk);
         checks++;
         if (got_b.size() != exp_b.size()) begin
            errors++; $display("FAIL rnd%0d_big_count got %0d required %0d", t, got_b.size(), exp_b.size());
         end
         for (int k = 0; k < got_b.size() && k < exp_b.size(); k++) begin
            checks++;
            if (got_b[k] !== exp_b[k]) begin
               errors++; $display("FAIL rnd%0d_big_word%0d got %h required %h", t, k, got_b[k], exp_b[k]);
            end
         end
         checks++;
         if ({b_err, b_done, b_cpu_rst, b_wc} !== {eb, ~eb, eb, 9'(wcb)}) begin
            errors++; $display("FAIL rnd%0d_big_status err/done/crst/wc=%b%b%b/%0d required %b%b%b/%0d",
                               t, b_err, b_done, b_cpu_rst, b_wc, eb, ~eb, eb, wcb);
         end
         checks++;
         if (got_s.size() != exp_s.size()) begin
            errors++; $display("FAIL rnd%0d_small_count got %0d required %0d", t, got_s.size(), exp_s.size());
         end
         for (int k = 0; k < got_s.size() && k < exp_s.size(); k++) begin
            checks++;
            if (got_s[k] !== exp_s[k]) begin
               errors++; $display("FAIL rnd%0d_small_word%0d got %h required %h", t, k, got_s[k], exp_s[k]);
            end
         end
         checks++;
         if ({s_err, s_done, s_cpu_rst, s_wc} !== {es, ~es, es, 3'(wcs)}) begin
            errors++; $display("FAIL rnd%0d_small_status err/done/crst/wc=%b%b%b/%0d required %b%b%b/%0d",
                               t, s_err, s_done, s_cpu_rst, s_wc, es, ~es, es, wcs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_overflow();
      test_abort();
      test_gap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
